// File: rtl/mem_access_if.sv
// Bundle of the execute-side input, data-memory request/response and
// writeback-side output signals of the memory access stage.
interface mem_access_if;
   // Execute-side input
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_mem_op;
   logic [1:0]  in_size;
   logic        in_unsigned;
   logic [63:0] in_addr;
   logic [63:0] in_wdata;
   logic [63:0] in_result;
   logic [4:0]  in_dst;
   logic [63:0] in_pc;

   // Data-memory request
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;

   // Data-memory response
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;

   // Writeback-side output
   logic        out_valid;
   logic [63:0] out_result;
   logic [4:0]  out_dst;
   logic [63:0] out_pc;
   logic        out_misalign;

   modport slave (
      input  in_valid, in_mem_op, in_size, in_unsigned, in_addr, in_wdata,
             in_result, in_dst, in_pc,
      output in_ready,
      output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  dresp_addr_ok, dresp_data_ok, dresp_data,
      output out_valid, out_result, out_dst, out_pc, out_misalign
   );

   modport master (
      output in_valid, in_mem_op, in_size, in_unsigned, in_addr, in_wdata,
             in_result, in_dst, in_pc,
      input  in_ready,
      input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output dresp_addr_ok, dresp_data_ok, dresp_data,
      input  out_valid, out_result, out_dst, out_pc, out_misalign
   );
endinterface

// File: rtl/mem_access.sv
// Memory access stage: accepts one execute result at a time, issues a
// single data-memory request for aligned loads/stores, aligns store data,
// extracts and extends load data, and presents one writeback beat.
module mem_access (
   input  logic         clk,
   input  logic         reset,
   mem_access_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   typedef enum logic [1:0] {OP_NONE = 2'b00, OP_LOAD = 2'b01,
                             OP_STORE = 2'b10, OP_RSVD = 2'b11} mem_op_t;

   state_t      state_q, state_d;

   mem_op_t     op_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [63:0] result_q;
   logic [4:0]  dst_q;
   logic [63:0] pc_q;
   logic        misalign_q;

   logic        accept;
   logic        in_is_mem;
   logic [2:0]  in_align_mask;
   logic        in_misalign;
   logic        data_done;
   logic [63:0] ld_shifted;
   logic [63:0] ld_ext;
   logic [63:0] st_data;
   logic [7:0]  st_strobe;

   assign accept    = bus.in_valid && (state_q == IDLE);
   assign in_is_mem = (bus.in_mem_op == OP_LOAD) || (bus.in_mem_op == OP_STORE);
   assign data_done = ((state_q == REQ) && bus.dresp_addr_ok && bus.dresp_data_ok) ||
                      ((state_q == WAIT) && bus.dresp_data_ok);

   // Alignment check of the incoming access: low address bits under the size mask must be zero
   always_comb begin
      in_align_mask = 3'b000;
      case (bus.in_size)
         2'd0: in_align_mask = 3'b000;
         2'd1: in_align_mask = 3'b001;
         2'd2: in_align_mask = 3'b011;
         2'd3: in_align_mask = 3'b111;
      endcase
      in_misalign = in_is_mem && ((bus.in_addr[2:0] & in_align_mask) != 3'b000);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.in_valid) state_d = (in_is_mem && !in_misalign) ? REQ : DONE;
         REQ:  if (bus.dresp_addr_ok) state_d = bus.dresp_data_ok ? DONE : WAIT;
         WAIT: if (bus.dresp_data_ok) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Load lane extraction and sign/zero extension from the 8-byte aligned response
   always_comb begin
      ld_shifted = bus.dresp_data >> {addr_q[2:0], 3'b000};
      ld_ext     = ld_shifted;
      case (size_q)
         2'd0: ld_ext = {{56{~uns_q & ld_shifted[7]}},  ld_shifted[7:0]};
         2'd1: ld_ext = {{48{~uns_q & ld_shifted[15]}}, ld_shifted[15:0]};
         2'd2: ld_ext = {{32{~uns_q & ld_shifted[31]}}, ld_shifted[31:0]};
         2'd3: ld_ext = ld_shifted;
      endcase
   end

   // Store lane placement: data and byte strobes shifted to the address offset
   always_comb begin
      st_data   = wdata_q << {addr_q[2:0], 3'b000};
      st_strobe = 8'h00;
      case (size_q)
         2'd0: st_strobe = 8'h01 << addr_q[2:0];
         2'd1: st_strobe = 8'h03 << addr_q[2:0];
         2'd2: st_strobe = 8'h0F << addr_q[2:0];
         2'd3: st_strobe = 8'hFF << addr_q[2:0];
      endcase
   end

   // Transaction capture on accept; the ALU result is preloaded and only a load overwrites it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q       <= OP_NONE;
         size_q     <= '0;
         uns_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         result_q   <= '0;
         dst_q      <= '0;
         pc_q       <= '0;
         misalign_q <= 1'b0;
      end else if (accept) begin
         op_q       <= mem_op_t'(bus.in_mem_op);
         size_q     <= bus.in_size;
         uns_q      <= bus.in_unsigned;
         addr_q     <= bus.in_addr;
         wdata_q    <= bus.in_wdata;
         result_q   <= bus.in_result;
         dst_q      <= bus.in_dst;
         pc_q       <= bus.in_pc;
         misalign_q <= in_misalign;
      end else if (data_done && (op_q == OP_LOAD)) begin
         result_q   <= ld_ext;
      end
   end

   assign bus.in_ready     = (state_q == IDLE);
   assign bus.dreq_valid   = (state_q == REQ);
   assign bus.dreq_addr    = (state_q == REQ) ? addr_q : '0;
   assign bus.dreq_size    = (state_q == REQ) ? {1'b0, size_q} : '0;
   assign bus.dreq_strobe  = ((state_q == REQ) && (op_q == OP_STORE)) ? st_strobe : '0;
   assign bus.dreq_data    = (state_q == REQ) ? st_data : '0;
   assign bus.out_valid    = (state_q == DONE);
   assign bus.out_result   = result_q;
   assign bus.out_dst      = dst_q;
   assign bus.out_pc       = pc_q;
   assign bus.out_misalign = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized
// transactions with randomized memory response timing, checked every
// cycle against a schedule/value model built from the stage's rules.
module tb_mem_access;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_access_if bus ();

   mem_access dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [1:0]  op;
      logic [1:0]  size;
      logic        uns;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] result;
      logic [4:0]  dst;
      logic [63:0] pc;
      logic [63:0] rdata;
   } txn_t;

   int n_checks = 0;
   int n_pass   = 0;

   // Expectations for the current cycle, set by the stimulus process
   bit          chk_en = 1'b0;
   bit          e_ready, e_dreq, e_out, e_zero;
   logic [63:0] e_daddr;
   logic [2:0]  e_dsize;
   logic [7:0]  e_strobe;
   logic [63:0] e_ddata;
   bit          e_chk_ddata;
   logic [63:0] e_res;
   bit          e_chk_res;
   logic [4:0]  e_dst;
   logic [63:0] e_pc;
   bit          e_mis;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Load value: pick the size-wide field at the byte offset, then extend
   function automatic logic [63:0] model_load(logic [63:0] data, logic [63:0] addr,
                                              logic [1:0] size, logic uns);
      int unsigned nbits;
      int unsigned sh;
      logic [63:0] v;
      logic [63:0] mask;
      nbits = 8 << size;
      sh    = 8 * addr[2:0];
      v     = data >> sh;
      mask  = (nbits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
      v     = v & mask;
      if (!uns && v[nbits-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [7:0] model_strobe(logic [1:0] size, logic [2:0] lo);
      int unsigned s;
      s = ((32'd1 << (32'd1 << size)) - 32'd1) << lo;
      return 8'(s);
   endfunction

   // Per-cycle compare of all DUT outputs against the current expectations
   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready",   64'(bus.in_ready),   64'(e_ready));
         chk("dreq_valid", 64'(bus.dreq_valid), 64'(e_dreq));
         chk("out_valid",  64'(bus.out_valid),  64'(e_out));
         if (e_zero) begin
            chk("rst_dreq_strobe",  64'(bus.dreq_strobe),  64'd0);
            chk("rst_dreq_addr",    bus.dreq_addr,         64'd0);
            chk("rst_dreq_data",    bus.dreq_data,         64'd0);
            chk("rst_dreq_size",    64'(bus.dreq_size),    64'd0);
            chk("rst_out_result",   bus.out_result,        64'd0);
            chk("rst_out_dst",      64'(bus.out_dst),      64'd0);
            chk("rst_out_pc",       bus.out_pc,            64'd0);
            chk("rst_out_misalign", 64'(bus.out_misalign), 64'd0);
         end
         if (e_dreq) begin
            chk("dreq_addr",   bus.dreq_addr,        e_daddr);
            chk("dreq_size",   64'(bus.dreq_size),   64'(e_dsize));
            chk("dreq_strobe", 64'(bus.dreq_strobe), 64'(e_strobe));
            if (e_chk_ddata) chk("dreq_data", bus.dreq_data, e_ddata);
         end
         if (e_out) begin
            chk("out_dst",      64'(bus.out_dst),      64'(e_dst));
            chk("out_pc",       bus.out_pc,            e_pc);
            chk("out_misalign", 64'(bus.out_misalign), 64'(e_mis));
            if (e_chk_res) chk("out_result", bus.out_result, e_res);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_in();
      bus.in_mem_op   = 2'($urandom);
      bus.in_size     = 2'($urandom);
      bus.in_unsigned = 1'($urandom);
      bus.in_addr     = rnd64();
      bus.in_wdata    = rnd64();
      bus.in_result   = rnd64();
      bus.in_dst      = 5'($urandom);
      bus.in_pc       = rnd64();
   endtask

   task automatic idle_cycle();
      bus.in_valid      = 1'b0;
      scramble_in();
      bus.dresp_addr_ok = 1'($urandom);
      bus.dresp_data_ok = 1'($urandom);
      bus.dresp_data    = rnd64();
      e_ready = 1'b1; e_dreq = 1'b0; e_out = 1'b0;
      step();
   endtask

   // One transaction: d REQ cycles without addr_ok, then addr_ok (with data_ok if same),
   // else w WAIT cycles without data_ok before data_ok. Literal overrides pin directed cases.
   task automatic txn(input txn_t t, input int unsigned d, input bit same, input int unsigned w,
                      input bit lit_res_en, input logic [63:0] lit_res,
                      input bit lit_req_en, input logic [7:0] lit_strobe, input logic [63:0] lit_data);
      bit         is_mem;
      bit         mis;
      logic [2:0] mask;
      is_mem = (t.op == 2'b01) || (t.op == 2'b10);
      mask   = 3'((32'd1 << t.size) - 32'd1);
      mis    = is_mem && ((t.addr[2:0] & mask) != 3'b000);

      bus.in_valid    = 1'b1;
      bus.in_mem_op   = t.op;
      bus.in_size     = t.size;
      bus.in_unsigned = t.uns;
      bus.in_addr     = t.addr;
      bus.in_wdata    = t.wdata;
      bus.in_result   = t.result;
      bus.in_dst      = t.dst;
      bus.in_pc       = t.pc;
      bus.dresp_addr_ok = 1'($urandom);
      bus.dresp_data_ok = 1'($urandom);
      bus.dresp_data    = rnd64();
      e_ready = 1'b1; e_dreq = 1'b0; e_out = 1'b0;
      step();

      e_ready = 1'b0;
      if (is_mem && !mis) begin
         for (int unsigned i = 0; i <= d; i++) begin
            bus.in_valid = 1'($urandom);
            scramble_in();
            e_dreq      = 1'b1;
            e_daddr     = t.addr;
            e_dsize     = {1'b0, t.size};
            e_chk_ddata = (t.op == 2'b10);
            e_strobe    = (t.op == 2'b10) ? (lit_req_en ? lit_strobe : model_strobe(t.size, t.addr[2:0])) : 8'h00;
            e_ddata     = lit_req_en ? lit_data : (t.wdata << (8 * t.addr[2:0]));
            bus.dresp_addr_ok = (i == d);
            bus.dresp_data_ok = (i == d) ? same : 1'($urandom);
            bus.dresp_data    = ((i == d) && same) ? t.rdata : rnd64();
            step();
         end
         e_dreq = 1'b0;
         if (!same) begin
            for (int unsigned j = 0; j <= w; j++) begin
               bus.in_valid = 1'($urandom);
               scramble_in();
               bus.dresp_addr_ok = 1'($urandom);
               bus.dresp_data_ok = (j == w);
               bus.dresp_data    = (j == w) ? t.rdata : rnd64();
               step();
            end
         end
      end

      bus.in_valid = 1'($urandom);
      scramble_in();
      bus.dresp_addr_ok = 1'($urandom);
      bus.dresp_data_ok = 1'($urandom);
      bus.dresp_data    = rnd64();
      e_out     = 1'b1;
      e_dst     = t.dst;
      e_pc      = t.pc;
      e_mis     = mis;
      e_chk_res = !mis;
      if (lit_res_en)          e_res = lit_res;
      else if (t.op == 2'b01)  e_res = model_load(t.rdata, t.addr, t.size, t.uns);
      else                     e_res = t.result;
      step();

      e_out = 1'b0;
      e_ready = 1'b1;
      bus.in_valid = 1'b0;
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
   endtask

   initial begin
      txn_t t;
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t t;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      scramble_in();
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      bus.dresp_data    = '0;
      e_ready = 1'b1; e_dreq = 1'b0; e_out = 1'b0; e_zero = 1'b1;
      chk_en = 1'b1;
      step();
      step();
      reset  = 1'b0;
      e_zero = 1'b0;
      idle_cycle();

      // ALU-only result
      t = '{op: 2'b00, size: 2'd3, uns: 1'b0, addr: 64'h3, wdata: 64'h0, result: 64'h1234,
            dst: 5'd7, pc: 64'h8000_0000, rdata: 64'h0};
      txn(t, 0, 1'b0, 0, 1'b1, 64'h1234, 1'b0, 8'h00, 64'h0);

      // Store byte at offset 5, addr_ok after three waiting REQ cycles
      t = '{op: 2'b10, size: 2'd0, uns: 1'b0, addr: 64'h8000_0005, wdata: 64'hAB,
            result: 64'h5555, dst: 5'd1, pc: 64'h8000_0004, rdata: 64'hFFFF_FFFF_FFFF_FFFF};
      txn(t, 3, 1'b0, 1, 1'b1, 64'h5555, 1'b1, 8'h20, 64'h0000_AB00_0000_0000);

      // Load half signed / unsigned at offset 2
      t = '{op: 2'b01, size: 2'd1, uns: 1'b0, addr: 64'h8000_1002, wdata: 64'h0,
            result: 64'h0, dst: 5'd2, pc: 64'h8000_0008, rdata: 64'h0000_0000_8001_0000};
      txn(t, 1, 1'b0, 2, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 8'h00, 64'h0);
      t.uns = 1'b1;
      txn(t, 0, 1'b0, 0, 1'b1, 64'h0000_0000_0000_8001, 1'b0, 8'h00, 64'h0);

      // Word load with addr_ok and data_ok in the same cycle
      t = '{op: 2'b01, size: 2'd2, uns: 1'b0, addr: 64'h8000_2004, wdata: 64'h0,
            result: 64'h0, dst: 5'd3, pc: 64'h8000_000C, rdata: 64'h89AB_CDEF_0000_0000};
      txn(t, 0, 1'b1, 0, 1'b1, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 8'h00, 64'h0);

      // Misaligned dword
      t = '{op: 2'b01, size: 2'd3, uns: 1'b0, addr: 64'h8000_3004, wdata: 64'h0,
            result: 64'h0, dst: 5'd4, pc: 64'h8000_0010, rdata: 64'h0};
      txn(t, 0, 1'b0, 0, 1'b0, 64'h0, 1'b0, 8'h00, 64'h0);

      // Reset pulsed while waiting for data; a late data_ok must be ignored
      bus.in_valid = 1'b1; bus.in_mem_op = 2'b01; bus.in_size = 2'd2; bus.in_unsigned = 1'b0;
      bus.in_addr = 64'h8000_4000; bus.in_result = 64'h77; bus.in_dst = 5'd5; bus.in_pc = 64'h8000_0014;
      bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0;
      e_ready = 1'b1; e_dreq = 1'b0; e_out = 1'b0;
      step();
      bus.in_valid = 1'b0;
      bus.dresp_addr_ok = 1'b1; bus.dresp_data_ok = 1'b0;
      e_ready = 1'b0; e_dreq = 1'b1; e_daddr = 64'h8000_4000; e_dsize = 3'd2;
      e_strobe = 8'h00; e_chk_ddata = 1'b0;
      step();
      bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0;
      e_dreq = 1'b0;
      #3;
      reset = 1'b1;
      e_ready = 1'b1; e_zero = 1'b1;
      #1;
      chk("async_rst_in_ready",   64'(bus.in_ready),   64'd1);
      chk("async_rst_dreq_valid", 64'(bus.dreq_valid), 64'd0);
      chk("async_rst_out_valid",  64'(bus.out_valid),  64'd0);
      step();
      reset  = 1'b0;
      e_zero = 1'b0;
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data    = 64'hDEAD_BEEF_DEAD_BEEF;
      step();
      bus.dresp_data_ok = 1'b0;
      step();

      // Randomized transactions with random response timing and idle gaps
      for (int n = 0; n < 300; n++) begin
         logic [2:0] m;
         t.op     = 2'($urandom);
         t.size   = 2'($urandom);
         t.uns    = 1'($urandom);
         t.addr   = rnd64();
         m        = 3'((32'd1 << t.size) - 32'd1);
         if ($urandom_range(0, 3) != 0) t.addr[2:0] = t.addr[2:0] & ~m;
         t.wdata  = rnd64();
         t.result = rnd64();
         t.dst    = 5'($urandom);
         t.pc     = rnd64();
         t.rdata  = rnd64();
         txn(t, $urandom_range(0, 3), ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
             1'b0, 64'h0, 1'b0, 8'h00, 64'h0);
         repeat ($urandom_range(0, 2)) idle_cycle();
      end

      idle_cycle();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 mem_access SHALL have one clock, clk, and an asynchronous active-high reset, reset; ports are listed as name, direction, width, meaning.
REQ-002 clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-high.
REQ-003 in_valid  in  1  execute-side result valid; in_ready  out  1  block can accept.
REQ-004 in_mem_op  in  2  memory operation: 00 none, 01 load, 10 store, 11 treated as none.
REQ-005 in_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword; in_unsigned  in  1  zero-extend load.
REQ-006 in_addr  in  64  effective address; in_wdata  in  64  store data (right-aligned).
REQ-007 in_result  in  64  ALU result; in_dst  in  5  destination register; in_pc  in  64  instruction PC.
REQ-008 dreq_valid  out  1; dreq_addr  out  64; dreq_size  out  3; dreq_strobe  out  8; dreq_data  out  64.
REQ-009 dresp_addr_ok  in  1  request accepted; dresp_data_ok  in  1  response valid; dresp_data  in  64  read data (8-byte aligned lane).
REQ-010 out_valid  out  1; out_result  out  64; out_dst  out  5; out_pc  out  64; out_misalign  out  1.

Function
REQ-011 FSM states SHALL be IDLE, REQ, WAIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-012 Handshake: in_valid && in_ready at a rising edge SHALL latch all in_* fields; in_* are ignored otherwise.
REQ-013 Accept with mem_op none/11 SHALL go IDLE->DONE; out_result = latched in_result; latency 1 cycle.
REQ-014 Misaligned access (addr mod (1<<size) != 0) SHALL go IDLE->DONE with out_misalign=1, no dreq_valid asserted.
REQ-015 Aligned load/store SHALL go IDLE->REQ; dreq_valid=1 in REQ only; dreq_* stable for the whole of REQ.
REQ-016 dreq_addr = latched addr; dreq_size = {0, size}.
REQ-017 Store: dreq_data = wdata << (8*addr[2:0]); dreq_strobe = ((1<<(1<<size))-1) << addr[2:0]; load: dreq_strobe = 0.
REQ-018 REQ with dresp_addr_ok=1 and dresp_data_ok=0 SHALL go to WAIT; both 1 in same cycle SHALL go directly to DONE.
REQ-019 WAIT SHALL hold until dresp_data_ok=1, then go to DONE; no limit on wait cycles.
REQ-020 Load data: field = dresp_data[8*addr[2:0] +: 8<<size], sign-extended to 64 bits unless in_unsigned, captured into out_result at the data_ok edge.
REQ-021 Store completion: out_result = latched in_result (dresp_data ignored).
REQ-022 DONE SHALL assert out_valid for exactly one cycle, then go to IDLE; out_result/out_dst/out_pc/out_misalign valid only while out_valid=1.
REQ-023 dresp_addr_ok/dresp_data_ok outside REQ/WAIT SHALL be ignored; dresp_data_ok in REQ without addr_ok SHALL be ignored.
REQ-024 Throughput: at most one operation per 2 cycles (non-memory), 3+ cycles (memory).

Reset
REQ-025 reset=1 SHALL force IDLE immediately (asynchronously), including mid-REQ/WAIT; pending transaction is dropped.
REQ-026 Reset values: in_ready=1, dreq_valid=0, dreq_strobe=0, out_valid=0, out_misalign=0, all data outputs 0.

Verification
REQ-027 ALU-only: mem_op=00, result=0x1234 -> out_valid one cycle after accept, out_result=0x1234, no dreq_valid.
REQ-028 Store byte: addr=0x80000005, size=0, wdata=0xAB -> dreq_strobe=0x20, dreq_data=0x0000AB0000000000; addr_ok after 3 cycles -> WAIT, data_ok -> out_valid.
REQ-029 Load half signed: addr=0x...2, dresp_data=0x00000000_80010000 -> out_result=0xFFFFFFFFFFFF8001; unsigned -> 0x8001.
REQ-030 addr_ok and data_ok same cycle on word load addr=0x...4, data=0x89ABCDEF_00000000 -> REQ->DONE, out_result=0xFFFFFFFF89ABCDEF.
REQ-031 Misaligned dword addr=0x...4 -> out_misalign=1 next cycle, dreq_valid never asserted.
REQ-032 reset pulsed in WAIT -> dreq_valid=0, out_valid=0, in_ready=1 immediately; late data_ok ignored.
